// File: rtl/sort_stream_out.sv
// ---------------------------------------------------------------------------
// sort_stream_out
//
// Purpose:
//   Output stage that sits behind the FSM sorter. When the sorter pulses done,
//   the whole sorted array is captured in one cycle. The array is then handed
//   to a serial consumer one element per valid/ready beat. m_last marks the
//   final beat. The block also counts completed frames, and it flags a sticky
//   overrun when a done pulse arrives while it cannot accept a new frame.
//
// Ports:
//   clk          in   1            single clock, everything on posedge
//   rst_n        in   1            synchronous active-low reset
//   done         in   1            sorter completion pulse, data_sorted valid
//   data_sorted  in   N x WIDTH    sorted array, element 0 = smallest
//   m_valid      out  1            output beat valid
//   m_ready      in   1            consumer accepts beat on m_valid && m_ready
//   m_data       out  WIDTH        element carried by the current beat
//   m_index      out  IDX_W        beat number within the frame, 0..N-1
//   m_last       out  1            high on beat N-1 only
//   busy         out  1            frame held/streaming, done must not pulse
//   overrun      out  1            sticky, a done pulse was dropped
//   ovr_clr      in   1            clears overrun (a same-cycle set wins)
//   frame_cnt    out  16           completed frames, wraps 0xFFFF -> 0
//
// Configuration macro:
//   SORT_OUT_DESC_EN  when defined, frames are emitted largest first, so beat k
//                     carries buffer[N-1-k]. m_index and m_last still count
//                     beats 0..N-1. When undefined, beat k carries buffer[k].
// ---------------------------------------------------------------------------
module sort_stream_out #(
  parameter  int N     = 6,
  parameter  int WIDTH = 8,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      done,
  input  logic [N-1:0][WIDTH-1:0]   data_sorted,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [WIDTH-1:0]          m_data,
  output logic [IDX_W-1:0]          m_index,
  output logic                      m_last,
  output logic                      busy,
  output logic                      overrun,
  input  logic                      ovr_clr,
  output logic [15:0]               frame_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                    r_state;
  state_t                    w_nextState;

  logic [N-1:0][WIDTH-1:0]   r_buffer;
  logic [IDX_W-1:0]          r_idx;
  logic [WIDTH-1:0]          r_mData;
  logic                      r_mLast;
  logic                      r_overrun;
  logic [15:0]               r_frameCnt;

  logic                      w_handshake;
  logic                      w_atLast;
  logic                      w_frameDone;
  logic                      w_capture;
  logic                      w_advance;
  logic                      w_overrunSet;
  logic [IDX_W-1:0]          w_nextIdx;
  logic [WIDTH-1:0]          w_capData;
  logic [WIDTH-1:0]          w_advData;

  // A beat is only ever on offer in STREAM, so m_ready is ignored elsewhere.
  // The final handshake of a frame is the single point where a new done can
  // be taken without dropping anything.
  assign w_handshake = (r_state == STREAM) && m_ready;
  assign w_atLast    = (r_idx == LAST_IDX);
  assign w_frameDone = w_handshake && w_atLast;
  assign w_nextIdx   = r_idx + IDX_W'(1);

  // Beat order selection. On capture the first beat comes straight from the
  // incoming array, because the buffer only receives it on the same edge.
  // While advancing, the next beat is read from the held buffer.
`ifdef SORT_OUT_DESC_EN
  assign w_capData = data_sorted[N-1];
  assign w_advData = r_buffer[LAST_IDX - w_nextIdx];
`else
  assign w_capData = data_sorted[0];
  assign w_advData = r_buffer[w_nextIdx];
`endif

  // Next-state logic. IDLE waits for done. STREAM walks the beats forward on
  // each handshake. At the last handshake, STREAM either chains straight into
  // a new frame (done present, no bubble) or goes back to IDLE. A done that
  // arrives at any other time in STREAM is dropped and raises overrun.
  always_comb begin
    w_nextState  = r_state;
    w_capture    = 1'b0;
    w_advance    = 1'b0;
    w_overrunSet = 1'b0;
    case (r_state)
      IDLE: begin
        if (done) begin
          w_capture   = 1'b1;
          w_nextState = STREAM;
        end
      end
      STREAM: begin
        if (w_handshake) begin
          if (w_atLast) begin
            if (done) begin
              w_capture = 1'b1;
            end else begin
              w_nextState = IDLE;
            end
          end else begin
            w_advance = 1'b1;
          end
        end
        if (done && !w_frameDone) begin
          w_overrunSet = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register. Reset always forces IDLE, even in the middle of a frame,
  // so no partial beats can leak out after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Frame buffer and beat registers. These values only change on a capture
  // or an advance, so they stay stable while the consumer stalls. m_last is
  // dropped when a frame ends without a follow-on capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buffer <= '0;
      r_idx    <= '0;
      r_mData  <= '0;
      r_mLast  <= 1'b0;
    end else if (w_capture) begin
      r_buffer <= data_sorted;
      r_idx    <= '0;
      r_mData  <= w_capData;
      r_mLast  <= (LAST_IDX == '0);
    end else if (w_advance) begin
      r_idx    <= w_nextIdx;
      r_mData  <= w_advData;
      r_mLast  <= (w_nextIdx == LAST_IDX);
    end else if (w_frameDone) begin
      r_mLast  <= 1'b0;
    end
  end

  // Status registers. The frame counter wraps naturally at 16 bits. When
  // overrun is set and cleared in the same cycle, the set takes priority so
  // that a dropped frame is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frameCnt <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_frameDone) begin
        r_frameCnt <= r_frameCnt + 16'd1;
      end
      if (w_overrunSet) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign m_valid   = (r_state == STREAM);
  assign busy      = (r_state == STREAM);
  assign m_data    = r_mData;
  assign m_index   = r_idx;
  assign m_last    = r_mLast;
  assign overrun   = r_overrun;
  assign frame_cnt = r_frameCnt;

endmodule
